parking_gate_ctrl: RTL

//  Parametrised car-park gate controller with password-checked entry, free exit,

---
 rtl/parking_gate_ctrl_pkg.sv | 31 +++
 rtl/parking_gate_ctrl_if.sv | 31 +++
 rtl/parking_gate_ctrl_timer.sv | 30 +++
 rtl/parking_gate_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types and helpers for the parking gate controller.
//   gate_state_e      : controller state encoding
//   DEFAULT_PASSWORD  : factory keypad code
//   occ_width()       : bits needed to hold a count 0..n
//   timer_width()     : bits needed for the largest of three cycle budgets
package parking_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitPw,
        StOpenIn,
        StOpenOut,
        StLockout
    } gate_state_e;

    localparam logic [3:0] DEFAULT_PASSWORD = 4'b0011;

    function automatic int unsigned occ_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor / keypad / actuator bundle of the parking gate controller.
//   master : environment side (drives sensors and keypad, observes gate status)
//   slave  : controller side
//   entry_req, exit_req, pw, pw_valid, car_passed : towards controller
//   gate_open, occupancy, full, deny, alarm       : from controller
interface parking_gate_if #(
    parameter int unsigned PW_W  = 4,
    parameter int unsigned OCC_W = 5
);
    logic             entry_req;
    logic             exit_req;
    logic [PW_W-1:0]  pw;
    logic             pw_valid;
    logic             car_passed;
    logic             gate_open;
    logic [OCC_W-1:0] occupancy;
    logic             full;
    logic             deny;
    logic             alarm;

    modport master (
        output entry_req, exit_req, pw, pw_valid, car_passed,
        input  gate_open, occupancy, full, deny, alarm
    );

    modport slave (
        input  entry_req, exit_req, pw, pw_valid, car_passed,
        output gate_open, occupancy, full, deny, alarm
    );

endinterface

// File: rtl/parking_gate_ctrl_timer.sv
// Loadable down-counter shared by all timed controller states.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i this edge (wins over counting)
//   load_val_i  : value to load
//   zero_o      : counter currently at zero (counter holds at zero)
module park_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park gate controller: password-checked entry, free exit, occupancy
// counting, retry limit with timed lockout, and gate / keypad timeouts.
//   clk, rst_n : clock, asynchronous active-low reset
//   gate       : slave side of parking_gate_if (sensors, keypad, gate status)
// All outputs are registered; full is decoded from the occupancy register.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned     PW_W        = 4,
    parameter logic [PW_W-1:0] PASSWORD    = PW_W'(DEFAULT_PASSWORD),
    parameter int unsigned     SLOTS       = 16,
    parameter int unsigned     MAX_TRIES   = 3,
    parameter int unsigned     PW_TIMEOUT  = 32,
    parameter int unsigned     GATE_HOLD   = 64,
    parameter int unsigned     LOCK_CYCLES = 128
) (
    input logic           clk,
    input logic           rst_n,
    parking_gate_if.slave gate
);

    localparam int unsigned OCC_W = occ_width(SLOTS);
    localparam int unsigned TRY_W = occ_width(MAX_TRIES);
    localparam int unsigned TMR_W = timer_width(PW_TIMEOUT, GATE_HOLD, LOCK_CYCLES);

    localparam logic [OCC_W-1:0] SLOTS_V   = OCC_W'(SLOTS);
    localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
    // Timer is loaded with N-1 so the timed state lasts exactly N cycles:
    // the zero flag is seen in the Nth cycle and the state is left on that edge.
    localparam logic [TMR_W-1:0] PW_LOAD   = TMR_W'(PW_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(GATE_HOLD - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);

    gate_state_e      state_q, state_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             gate_open_q, gate_open_d;
    logic             deny_q, deny_d;
    logic             alarm_q, alarm_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_zero;
    logic             full;
    logic             pw_ok;

    assign full  = (occupancy_q == SLOTS_V);
    assign pw_ok = (gate.pw == PASSWORD);

    park_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        occupancy_d  = occupancy_q;
        tries_d      = tries_q;
        deny_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        unique case (state_q)
            StIdle: begin
                // Exit wins over entry so a leaving car frees its slot first.
                if (gate.exit_req && (occupancy_q != '0)) begin
                    state_d      = StOpenOut;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LOAD;
                end else if (gate.entry_req && !full) begin
                    state_d      = StWaitPw;
                    tmr_load     = 1'b1;
                    tmr_load_val = PW_LOAD;
                end else if (gate.entry_req) begin
                    deny_d = 1'b1;
                end
            end

            StWaitPw: begin
                // A strobe in the final cycle still counts.
                if (gate.pw_valid) begin
                    if (pw_ok) begin
                        state_d      = StOpenIn;
                        tries_d      = '0;
                        tmr_load     = 1'b1;
                        tmr_load_val = HOLD_LOAD;
                    end else begin
                        deny_d   = 1'b1;
                        tries_d  = tries_q + TRY_W'(1);
                        tmr_load = 1'b1;
                        if (tries_q == LAST_TRY) begin
                            state_d      = StLockout;
                            tmr_load_val = LOCK_LOAD;
                        end else begin
                            tmr_load_val = PW_LOAD;
                        end
                    end
                end else if (tmr_zero) begin
                    state_d = StIdle;
                end
            end

            StOpenIn: begin
                // car_passed is checked before the timeout so a car clearing
                // in the last cycle is still counted.
                if (gate.car_passed) begin
                    state_d = StIdle;
                    if (occupancy_q != SLOTS_V) begin
                        occupancy_d = occupancy_q + OCC_W'(1);
                    end
                end else if (tmr_zero) begin
                    state_d = StIdle;
                end
            end

            StOpenOut: begin
                if (gate.car_passed) begin
                    state_d = StIdle;
                    if (occupancy_q != '0) begin
                        occupancy_d = occupancy_q - OCC_W'(1);
                    end
                end else if (tmr_zero) begin
                    state_d = StIdle;
                end
            end

            StLockout: begin
                if (tmr_zero) begin
                    state_d = StIdle;
                    tries_d = '0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        gate_open_d = (state_d == StOpenIn) || (state_d == StOpenOut);
        alarm_d     = (state_d == StLockout);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            occupancy_q <= '0;
            tries_q     <= '0;
            gate_open_q <= 1'b0;
            deny_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            occupancy_q <= occupancy_d;
            tries_q     <= tries_d;
            gate_open_q <= gate_open_d;
            deny_q      <= deny_d;
            alarm_q     <= alarm_d;
        end
    end

    assign gate.gate_open = gate_open_q;
    assign gate.occupancy = occupancy_q;
    assign gate.full      = full;
    assign gate.deny      = deny_q;
    assign gate.alarm     = alarm_q;

endmodule
